// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control sequencer: opcodes, FSM states,
// the HALT encoding and the fixed branch-target table.
package alu_ctrl_pkg;

  localparam int LUT_W = 10;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_ADD  = 3'b001,
    OP_BLTE = 3'b010,
    OP_XOR  = 3'b011,
    OP_CNT  = 3'b100,
    OP_LDM  = 3'b101,
    OP_STM  = 3'b110,
    OP_BGTE = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_DONE
  } state_e;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  localparam logic [LUT_W-1:0] BRANCH_LUT [8] = '{
    10'd0, 10'd64, 10'd128, 10'd192, 10'd256, 10'd320, 10'd384, 10'd448
  };

  function automatic logic [LUT_W-1:0] branch_target(input logic [2:0] idx);
    return BRANCH_LUT[idx];
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Start/Done handshake, instruction ROM and datapath control bundle of the
// sequencer. The sequencer uses the slave modport; its environment uses master.
interface alu_ctrl_seq_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [8:0]       Instr;
  logic             Jen;
  logic [PC_W-1:0]  PC;
  logic [2:0]       RaddrA;
  logic [2:0]       RaddrB;
  logic [2:0]       Aluop;
  logic             Inc;
  logic             RegWen;
  logic [2:0]       RegWaddr;
  logic             WbSel;
  logic             MemRen;
  logic             MemWen;
  logic             Done;
  logic [CNT_W-1:0] CycleCnt;

  modport slave (
    input  Start, Instr, Jen,
    output PC, RaddrA, RaddrB, Aluop, Inc, RegWen, RegWaddr, WbSel,
           MemRen, MemWen, Done, CycleCnt
  );

  modport master (
    output Start, Instr, Jen,
    input  PC, RaddrA, RaddrB, Aluop, Inc, RegWen, RegWaddr, WbSel,
           MemRen, MemWen, Done, CycleCnt
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction classifier: turns an instruction word into the
// control flags the sequencer steers its state machine with.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [8:0] ir_i,
  output logic       inc_o,
  output logic       is_branch_o,
  output logic       is_ld_o,
  output logic       is_st_o,
  output logic       is_halt_o,
  output logic       writes_reg_o
);
  opcode_e op;

  always_comb begin
    op           = opcode_e'(ir_i[8:6]);
    // HALT shares the BGTE opcode, so it must mask the branch decode
    is_halt_o    = (ir_i == HALT_INSTR);
    is_branch_o  = !is_halt_o && ((op == OP_BLTE) || (op == OP_BGTE));
    is_ld_o      = (op == OP_LDM);
    is_st_o      = (op == OP_STM);
    inc_o        = (op == OP_ADD) && (ir_i[5:3] == ir_i[2:0]);
    writes_reg_o = (op == OP_AND) || (op == OP_ADD) || (op == OP_XOR) ||
                   (op == OP_CNT) || (op == OP_LDM);
  end
endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the 8-bit ALU datapath.
// Optional cycle counter enabled by defining ALU_CTRL_CYC_CNT_EN.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input logic           Clk,
  input logic           Reset_n,
  alu_ctrl_seq_if.slave bus
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic            regwen_q, regwen_d;
  logic            wbsel_q, wbsel_d;
  logic            memren_q, memren_d;
  logic            memwen_q, memwen_d;
  logic            done_q, done_d;

  logic dec_inc, dec_branch, dec_ld, dec_st, dec_halt, dec_wreg;

  // During DECODE the ROM word is classified directly, everywhere else IR is
  assign ir_d = (state_q == ST_DECODE) ? bus.Instr : ir_q;

  alu_ctrl_decode u_decode (
    .ir_i         (ir_d),
    .inc_o        (dec_inc),
    .is_branch_o  (dec_branch),
    .is_ld_o      (dec_ld),
    .is_st_o      (dec_st),
    .is_halt_o    (dec_halt),
    .writes_reg_o (dec_wreg)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = dec_halt ? ST_DONE : ST_EXEC;
      ST_EXEC: begin
        if (dec_branch) begin
          pc_d    = bus.Jen ? PC_W'(branch_target(ir_q[2:0])) : pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end else if (dec_ld || dec_st) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dec_st) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it
    regwen_d = (state_d == ST_WB) && dec_wreg;
    wbsel_d  = (state_d == ST_WB) && dec_ld;
    memren_d = (state_d == ST_MEM) && dec_ld;
    memwen_d = (state_d == ST_MEM) && dec_st;
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      regwen_q <= 1'b0;
      wbsel_q  <= 1'b0;
      memren_q <= 1'b0;
      memwen_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      regwen_q <= regwen_d;
      wbsel_q  <= wbsel_d;
      memren_q <= memren_d;
      memwen_q <= memwen_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_CTRL_CYC_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle_or_done;

  always_comb begin
    idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    cnt_d        = cnt_q;
    if (idle_or_done && bus.Start) begin
      cnt_d = '0;
    end else if (!idle_or_done && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.CycleCnt = cnt_q;
`else
  assign bus.CycleCnt = {CNT_W{1'b0}};
`endif

  assign bus.PC       = pc_q;
  assign bus.Aluop    = ir_q[8:6];
  assign bus.RaddrA   = ir_q[5:3];
  assign bus.RaddrB   = ir_q[2:0];
  assign bus.RegWaddr = ir_q[5:3];
  assign bus.Inc      = dec_inc && (state_q == ST_EXEC);
  assign bus.RegWen   = regwen_q;
  assign bus.WbSel    = wbsel_q;
  assign bus.MemRen   = memren_q;
  assign bus.MemWen   = memwen_q;
  assign bus.Done     = done_q;
endmodule
